// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, CTRL fields, mode codes and FSM encoding for timer_dev
package timer_dev_pkg;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Modes 10 and 11 fall back to one-shot, so only 01 reloads.
    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with CTRL/PRESET/COUNT registers and level IRQ
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;

    logic unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            // COUNT is loaded on the way into LOAD, so the LOAD cycle is already
            // the first countdown tick and pending rises PRESET+1 edges after enable.
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    count_d = preset_q;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                    state_d = ST_CNT;
                end else begin
                    count_d   = 32'd0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    pending_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A CPU write to CTRL overrides whatever the FSM decided this edge.
        if (WE) begin
            case (Addr[3:2])
                CTRL_OFF: begin
                    ctrl_d    = WD[3:0];
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                    count_d   = count_q;
                end
                PRESET_OFF: preset_d = WD;
                default: ;
            endcase
        end

        irq_d = ctrl_d[CTRL_IM] & pending_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 4'd0;
            preset_q  <= RESET_PRESET;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        case (Addr[3:2])
            CTRL_OFF:   RD = {28'd0, ctrl_q};
            PRESET_OFF: RD = preset_q;
            COUNT_OFF:  RD = count_q;
            default:    RD = 32'd0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev: directed bus cycles push expectations, negedge monitor checks
module tb_timer_dev;
    import timer_dev_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr  = 32'd0;
    logic        WE    = 1'b0;
    logic [31:0] WD    = 32'd0;
    logic [31:0] RD;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_v = 1'b0;
    logic [1:0]  probe = 2'b00;
    logic [31:0] exp_q[$];
    logic        is_irq_q[$];
    string       name_q[$];

    timer_dev #(.RESET_PRESET(32'd0)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .WD   (WD),
        .RD   (RD),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // One bus cycle: inputs driven just after the rising edge, checks taken at the falling edge.
    task automatic cyc(input logic we, input logic [1:0] off, input logic [31:0] wd,
                       input logic [1:0] mask, input logic [31:0] erd, input logic eirq,
                       input string nm);
        @(posedge clk);
        #1;
        reset = rst_v;
        WE    = we;
        Addr  = 32'h0000_7F00 | {28'd0, off, 2'b00};
        WD    = wd;
        probe = mask;
        if (mask[0]) begin
            exp_q.push_back(erd);
            is_irq_q.push_back(1'b0);
            name_q.push_back({nm, "_rd"});
        end
        if (mask[1]) begin
            exp_q.push_back({31'd0, eirq});
            is_irq_q.push_back(1'b1);
            name_q.push_back({nm, "_irq"});
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] wd);
        cyc(1'b1, off, wd, 2'b00, 32'd0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] erd, input string nm);
        cyc(1'b0, off, 32'd0, 2'b01, erd, 1'b0, nm);
    endtask

    task automatic irq(input logic eirq, input string nm);
        cyc(1'b0, CTRL_OFF, 32'd0, 2'b10, 32'd0, eirq, nm);
    endtask

    task automatic rdi(input logic [1:0] off, input logic [31:0] erd, input logic eirq, input string nm);
        cyc(1'b0, off, 32'd0, 2'b11, erd, eirq, nm);
    endtask

    task automatic pop_check(input logic [31:0] act_rd, input logic act_irq);
        logic [31:0] e;
        logic [31:0] a;
        logic        k;
        string       n;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got RD=%h IRQ=%b, required a queued expectation", act_rd, act_irq);
            return;
        end
        e = exp_q.pop_front();
        k = is_irq_q.pop_front();
        n = name_q.pop_front();
        a = k ? {31'd0, act_irq} : act_rd;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (probe[0]) pop_check(RD, IRQ);
        if (probe[1]) pop_check(RD, IRQ);
    end

    initial begin
        // Reset held for two edges, then reset values on every offset.
        rst_v = 1'b0;
        cyc(1'b0, CTRL_OFF, 32'd0, 2'b00, 32'd0, 1'b0, "rst");
        cyc(1'b0, CTRL_OFF, 32'd0, 2'b00, 32'd0, 1'b0, "rst");
        rst_v = 1'b1;
        rdi(CTRL_OFF, 32'd0, 1'b0, "rst_ctrl");
        rd(PRESET_OFF, 32'd0, "rst_preset");
        rd(COUNT_OFF, 32'd0, "rst_count");
        rd(2'd3, 32'd0, "rst_rsvd");

        // One-shot, PRESET=5: COUNT 5..0, IRQ six edges after the enable write.
        wr(PRESET_OFF, 32'd5);
        wr(CTRL_OFF, 32'h9);
        rdi(COUNT_OFF, 32'd0, 1'b0, "os_idle");
        for (int k = 0; k < 5; k++) rdi(COUNT_OFF, 32'd5 - k, 1'b0, "os_cnt");
        rdi(COUNT_OFF, 32'd0, 1'b1, "os_expire");
        rdi(CTRL_OFF, 32'h8, 1'b1, "os_ctrl_en_clr");
        rdi(CTRL_OFF, 32'h8, 1'b1, "os_irq_held");
        cyc(1'b1, CTRL_OFF, 32'h8, 2'b11, 32'h8, 1'b1, "os_clr_wr");
        rdi(CTRL_OFF, 32'h8, 1'b0, "os_irq_cleared");

        // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles, CTRL stays 0xB.
        wr(PRESET_OFF, 32'd3);
        wr(CTRL_OFF, 32'hB);
        for (int k = 1; k <= 16; k++) rdi(CTRL_OFF, 32'hB, (k % 5) == 0, "ar");
        wr(CTRL_OFF, 32'hFFFF_FFF0);
        rd(CTRL_OFF, 32'd0, "ctrl_high_bits_dropped");
        wr(COUNT_OFF, 32'd123);
        rd(COUNT_OFF, 32'd3, "count_ro");
        wr(2'd3, 32'd5);
        rd(2'd3, 32'd0, "rsvd_ro");

        // Masked expiry, then CTRL writes clear pending.
        wr(PRESET_OFF, 32'd2);
        wr(CTRL_OFF, 32'h1);
        for (int k = 0; k < 6; k++) irq(1'b0, "mask_off");
        cyc(1'b1, CTRL_OFF, 32'h8, 2'b10, 32'd0, 1'b0, "mask_set_wr");
        rdi(CTRL_OFF, 32'h8, 1'b0, "mask_clr_pend");
        wr(CTRL_OFF, 32'h1);
        for (int k = 0; k < 4; k++) irq(1'b0, "mask_off2");
        cyc(1'b1, CTRL_OFF, 32'h9, 2'b11, 32'h0, 1'b0, "mask_restart_wr");
        irq(1'b0, "restart_clr_pend");
        irq(1'b0, "restart_load");
        irq(1'b0, "restart_cnt");
        irq(1'b1, "restart_fire");
        wr(CTRL_OFF, 32'h0);

        // Disable mid-count freezes COUNT; PRESET write does not disturb it.
        wr(PRESET_OFF, 32'd100);
        wr(CTRL_OFF, 32'h1);
        for (int k = 0; k < 8; k++) irq(1'b0, "dis_run");
        rdi(COUNT_OFF, 32'd93, 1'b0, "dis_cnt93");
        cyc(1'b1, CTRL_OFF, 32'h0, 2'b01, 32'h1, 1'b0, "dis_wr_prewrite");
        rdi(COUNT_OFF, 32'd92, 1'b0, "dis_frozen");
        wr(PRESET_OFF, 32'hFFFF);
        rdi(COUNT_OFF, 32'd92, 1'b0, "dis_frozen_after_preset");
        rd(PRESET_OFF, 32'hFFFF, "dis_preset");

        // Collision: CTRL rewrite on the expiry edge wins, then a fresh load fires.
        wr(PRESET_OFF, 32'd1);
        wr(CTRL_OFF, 32'h9);
        irq(1'b0, "col_load");
        cyc(1'b1, CTRL_OFF, 32'h9, 2'b10, 32'd0, 1'b0, "col_wr");
        rdi(COUNT_OFF, 32'd1, 1'b0, "col_pend0");
        rdi(COUNT_OFF, 32'd1, 1'b0, "col_reload");
        rdi(COUNT_OFF, 32'd0, 1'b1, "col_fire");

        // Reset mid-count.
        wr(PRESET_OFF, 32'd50);
        wr(CTRL_OFF, 32'h9);
        irq(1'b0, "rst_mid_idle");
        irq(1'b0, "rst_mid_load");
        rdi(COUNT_OFF, 32'd49, 1'b0, "rst_mid_cnt");
        rst_v = 1'b0;
        cyc(1'b0, CTRL_OFF, 32'd0, 2'b00, 32'd0, 1'b0, "rst_mid");
        rst_v = 1'b1;
        rdi(CTRL_OFF, 32'd0, 1'b0, "rst_mid_ctrl");
        rd(PRESET_OFF, 32'd0, "rst_mid_preset");
        rd(COUNT_OFF, 32'd0, "rst_mid_count");
        for (int k = 0; k < 60; k++) irq(1'b0, "rst_mid_noirq");

        cyc(1'b0, CTRL_OFF, 32'd0, 2'b00, 32'd0, 1'b0, "drain");
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
